// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Resolves register
//   data hazards (with or without forwarding), taken branches from EXE and
//   fixed-latency SRAM accesses. It also keeps two saturating event counters.
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_src1/i_src2 (+valid)  ID-stage source register indices
//   i_exe_wb_en/i_exe_dest  EXE-stage writeback info
//   i_exe_mem_r_en          EXE-stage instruction is a load
//   i_mem_wb_en/i_mem_dest  MEM-stage writeback info
//   i_fwd_en                forwarding unit enabled
//   i_branch_taken          EXE-stage branch taken
//   i_mem_req               MEM-stage memory access request
//   o_*_freeze/_flush       stage register controls
//   o_mem_wb_bubble         clear MEM/WB input
//   o_sram_start            one-cycle SRAM access start pulse
//   o_hazard_cnt            hazard bubbles inserted (saturating)
//   o_mem_stall_cnt         cycles frozen for memory (saturating)
//
// FSM states
//   RUN      | normal flow; a mem_req starts an access and freezes the pipe
//   MEM_WAIT | SRAM busy; pipe frozen while wait counter runs down
//   MEM_DONE | data ready; one unfrozen cycle, mem_req ignored
module pipeline_hazard_ctrl #(
  parameter int SRAM_WAIT = 4,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_src1,
  input  logic [3:0]       i_src2,
  input  logic             i_src1_valid,
  input  logic             i_src2_valid,
  input  logic             i_exe_wb_en,
  input  logic [3:0]       i_exe_dest,
  input  logic             i_exe_mem_r_en,
  input  logic             i_mem_wb_en,
  input  logic [3:0]       i_mem_dest,
  input  logic             i_fwd_en,
  input  logic             i_branch_taken,
  input  logic             i_mem_req,
  output logic             o_pc_freeze,
  output logic             o_if_id_freeze,
  output logic             o_if_id_flush,
  output logic             o_id_exe_freeze,
  output logic             o_id_exe_flush,
  output logic             o_exe_mem_freeze,
  output logic             o_mem_wb_bubble,
  output logic             o_sram_start,
  output logic [CNT_W-1:0] o_hazard_cnt,
  output logic [CNT_W-1:0] o_mem_stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(SRAM_WAIT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_wait_cnt;
  logic [3:0]       w_next_wait_cnt;
  logic             w_mem_freeze;
  logic             w_sram_start;
  logic [CNT_W-1:0] r_hazard_cnt;
  logic [CNT_W-1:0] r_mem_stall_cnt;

  logic w_exe_match;
  logic w_mem_match;
  logic w_hz_raw;
  logic w_hz;
  logic w_branch;
  logic w_hz_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= RUN;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_mem_freeze    = 1'b0;
    w_sram_start    = 1'b0;
    case (r_state)
      RUN: begin
        if (i_mem_req) begin
          w_mem_freeze    = 1'b1;
          w_sram_start    = 1'b1;
          w_next_state    = MEM_WAIT;
          w_next_wait_cnt = WAIT_INIT;
        end
      end
      MEM_WAIT: begin
        w_mem_freeze = 1'b1;
        if (r_wait_cnt == 4'd0) begin
          w_next_state = MEM_DONE;
        end else begin
          w_next_wait_cnt = r_wait_cnt - 4'd1;
        end
      end
      MEM_DONE: begin
        // The memory instruction is still in MEM this cycle; its mem_req
        // must not start a second access.
        w_next_state = RUN;
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  // Index 15 (PC) is intentionally not excluded from matching.
  assign w_exe_match = i_exe_wb_en &
                       ((i_src1_valid & (i_src1 == i_exe_dest)) |
                        (i_src2_valid & (i_src2 == i_exe_dest)));
  assign w_mem_match = i_mem_wb_en &
                       ((i_src1_valid & (i_src1 == i_mem_dest)) |
                        (i_src2_valid & (i_src2 == i_mem_dest)));

  // With forwarding only a load-use on the EXE result needs a bubble.
  assign w_hz_raw   = i_fwd_en ? (w_exe_match & i_exe_mem_r_en)
                               : (w_exe_match | w_mem_match);
  assign w_hz       = w_hz_raw & ~w_mem_freeze;
  // A branch seen during a memory freeze stays in ID/EXE and is acted on
  // in the MEM_DONE cycle, when the freeze drops.
  assign w_branch   = i_branch_taken & ~w_mem_freeze;
  assign w_hz_stall = w_hz & ~i_branch_taken;

  assign o_pc_freeze      = w_mem_freeze | w_hz_stall;
  assign o_if_id_freeze   = w_mem_freeze | w_hz_stall;
  assign o_if_id_flush    = w_branch;
  assign o_id_exe_freeze  = w_mem_freeze;
  assign o_id_exe_flush   = w_branch | w_hz_stall;
  assign o_exe_mem_freeze = w_mem_freeze;
  assign o_mem_wb_bubble  = w_mem_freeze;
  assign o_sram_start     = w_sram_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hazard_cnt    <= '0;
      r_mem_stall_cnt <= '0;
    end else begin
      if (w_hz_stall && (r_hazard_cnt != '1)) begin
        r_hazard_cnt <= r_hazard_cnt + CNT_W'(1);
      end
      if (w_mem_freeze && (r_mem_stall_cnt != '1)) begin
        r_mem_stall_cnt <= r_mem_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_hazard_cnt    = r_hazard_cnt;
  assign o_mem_stall_cnt = r_mem_stall_cnt;

endmodule
